// File: rtl/round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
//
// Purpose:
//   N-way round-robin arbiter with a registered one-hot grant. A rotating
//   priority pointer makes sure every requester is served in turn. When a
//   grant is released, the next winner is registered on the same clock edge,
//   so there is no idle cycle between two grants.
//
// Optional feature (macro ARB_PKT_LOCK_EN):
//   undefined : the grant is released after every accepted beat.
//   defined   : the in_last port exists. The grant stays on one requester
//               until that requester's beat is accepted with in_last = 1.
//
// Ports:
//   clk        in   1   clock; all state changes on the rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   N   per-requester valid; bit k belongs to requester k
//   in_ready   out  N   out_ready steered to the granted requester only
//   in_last    in   1   last beat of the granted stream (ARB_PKT_LOCK_EN only)
//   out_valid  out  1   the granted requester has a beat for downstream
//   out_ready  in   1   downstream accepts a beat
//   gnt        out  N   registered one-hot grant, used as a mux select
//   gnt_idx    out  IW  binary index of the set gnt bit; 0 when idle
// ---------------------------------------------------------------------------
module round_robin_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_valid,
    output logic [N-1:0]  in_ready,
`ifdef ARB_PKT_LOCK_EN
    input  logic          in_last,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  gnt_nxt;
    logic [IW-1:0] idx_nxt;
    logic [IW-1:0] ptr, ptr_nxt;

    logic          accept;
    logic          rel;
    logic [IW-1:0] ptr_rel;
    logic [IW-1:0] base;
    logic          pick_found;
    logic [IW-1:0] pick_idx;

    // Return the first set bit of v, searching from base upward and
    // wrapping modulo N. Result is {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0]  v,
                                            input logic [IW-1:0] start);
        logic          found;
        logic [IW-1:0] idx;
        int            k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(start) + i;
            if (k >= N) k = k - N;
            if (!found && v[k]) begin
                found = 1'b1;
                idx   = IW'(k);
            end
        end
        return {found, idx};
    endfunction

    // These outputs depend only on the registered grant and on current
    // inputs. out_ready reaches in_ready, but never out_valid or gnt.
    assign out_valid = |(in_valid & gnt);
    assign in_ready  = gnt & {N{out_ready}};
    assign accept    = out_valid & out_ready;

`ifdef ARB_PKT_LOCK_EN
    assign rel = accept & in_last;
`else
    assign rel = accept;
`endif

    // Pointer value after a release: the slot just after the current winner.
    assign ptr_rel = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;

    // On a release, search from the updated pointer. This lets the next
    // winner be registered on the release edge (zero-bubble hand-over).
    // The requester just released is checked last, so it only wins again
    // when no other requester is valid.
    assign base = (state == GRANT) ? ptr_rel : ptr;
    assign {pick_found, pick_idx} = rr_pick(in_valid, base);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt         = GRANT;
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                    idx_nxt           = pick_idx;
                end
            end
            GRANT: begin
                // Hold the grant until it is released, even in cycles
                // where the granted requester drops in_valid.
                if (rel) begin
                    ptr_nxt = ptr_rel;
                    if (pick_found) begin
                        gnt_nxt           = '0;
                        gnt_nxt[pick_idx] = 1'b1;
                        idx_nxt           = pick_idx;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        idx_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // gnt_idx is registered together with gnt, so it always matches the
    // encoded value of gnt without an encoder on the output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            ptr     <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed-vector bench for round_robin_arbiter (N = 4). Each table row
// gives the inputs for one cycle and the hand-computed outputs expected in
// that cycle. The driver pushes those expectations into a scoreboard queue.
// A monitor on the falling edge pops each entry and compares it with the DUT.
module tb_round_robin_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  in_valid = '0;
    logic [N-1:0]  in_ready;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;

    always #5 clk = ~clk;

    round_robin_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef ARB_PKT_LOCK_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx)
    );

    typedef struct {
        logic       r;
        logic [3:0] iv;
        logic       o;
        logic       l;
        logic       c;
        logic [3:0] g;
        logic [1:0] gi;
        logic       ov;
        logic [3:0] ir;
    } vec_t;

    typedef struct {
        int         row;
        logic [3:0] g;
        logic [1:0] gi;
        logic       ov;
        logic [3:0] ir;
    } exp_t;

    vec_t stim[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic v(input logic r, input logic [3:0] iv, input logic o,
                     input logic l, input logic c, input logic [3:0] g,
                     input logic [1:0] gi, input logic ov, input logic [3:0] ir);
        vec_t x;
        x.r = r; x.iv = iv; x.o = o; x.l = l; x.c = c;
        x.g = g; x.gi = gi; x.ov = ov; x.ir = ir;
        stim.push_back(x);
    endtask

    task automatic cmp(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    // Monitor: samples away from the rising edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp("gnt",       e.row, 32'(gnt),       32'(e.g));
            cmp("gnt_idx",   e.row, 32'(gnt_idx),   32'(e.gi));
            cmp("out_valid", e.row, 32'(out_valid), 32'(e.ov));
            cmp("in_ready",  e.row, 32'(in_ready),  32'(e.ir));
        end
    end

    initial begin
        // Columns: rst, in_valid, out_ready, in_last, check, gnt, gnt_idx, out_valid, in_ready
        // Reset, then all requesters valid with downstream always ready.
        v(1, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 4'b0000);
        v(1, 4'b0000, 0, 1, 1, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b1111, 1, 1, 1, 4'b0000, 0, 0, 4'b0000); // idle: no in_ready
        v(0, 4'b1111, 1, 1, 1, 4'b0001, 0, 1, 4'b0001);
        v(0, 4'b1111, 1, 1, 1, 4'b0010, 1, 1, 4'b0010);
        v(0, 4'b1111, 1, 1, 1, 4'b0100, 2, 1, 4'b0100);
        v(0, 4'b1111, 1, 1, 1, 4'b1000, 3, 1, 4'b1000);
        v(0, 4'b0000, 1, 1, 1, 4'b0001, 0, 0, 4'b0001); // valid dropped, grant held
        v(0, 4'b0000, 0, 1, 1, 4'b0001, 0, 0, 4'b0000);
        // Reset, then a single requester (2) stalled for 5 cycles.
        v(1, 4'b0000, 0, 1, 1, 4'b0001, 0, 0, 4'b0000);
        v(0, 4'b0100, 0, 1, 1, 4'b0000, 0, 0, 4'b0000);
        for (int i = 0; i < 5; i++)
            v(0, 4'b0100, 0, 1, 1, 4'b0100, 2, 1, 4'b0000);
        v(0, 4'b0100, 1, 1, 1, 4'b0100, 2, 1, 4'b0100); // the only accept
        v(0, 4'b0100, 0, 1, 1, 4'b0100, 2, 1, 4'b0000); // sole requester wins again
        // Wrap-around: release 2 -> ptr=3, requesters {0,1,2} -> 0
        v(0, 4'b0111, 1, 1, 1, 4'b0100, 2, 1, 4'b0100);
        v(0, 4'b0011, 0, 1, 1, 4'b0001, 0, 1, 4'b0000);
        v(0, 4'b0011, 1, 1, 1, 4'b0001, 0, 1, 4'b0001);
        v(0, 4'b0000, 1, 1, 1, 4'b0010, 1, 0, 4'b0010);
        v(0, 4'b0010, 1, 1, 1, 4'b0010, 1, 1, 4'b0010); // sole requester -> re-grant
        v(0, 4'b1010, 1, 1, 1, 4'b0010, 1, 1, 4'b0010); // now 3 beats 1
        v(0, 4'b1010, 0, 1, 1, 4'b1000, 3, 1, 4'b0000);
        // Reset while gnt=1000, out_ready=0
        v(1, 4'b1010, 0, 1, 1, 4'b1000, 3, 1, 4'b0000);
        v(0, 4'b1010, 0, 1, 1, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b1010, 0, 1, 1, 4'b0010, 1, 1, 4'b0000); // lowest valid index wins
        v(0, 4'b1010, 1, 1, 1, 4'b0010, 1, 1, 4'b0010);
        v(0, 4'b0000, 0, 1, 1, 4'b1000, 3, 0, 4'b0000);
        v(0, 4'b0000, 1, 1, 1, 4'b1000, 3, 0, 4'b1000); // no accept without valid
        v(0, 4'b1001, 1, 1, 1, 4'b1000, 3, 1, 4'b1000); // release N-1 -> ptr 0
        v(0, 4'b0000, 0, 1, 1, 4'b0001, 0, 0, 4'b0000);
`ifdef ARB_PKT_LOCK_EN
        // Packet lock: requester 1 sends 3 beats, last on the 3rd.
        v(1, 4'b0000, 0, 0, 1, 4'b0001, 0, 0, 4'b0000);
        v(0, 4'b0010, 0, 0, 1, 4'b0000, 0, 0, 4'b0000);
        v(0, 4'b1111, 1, 0, 1, 4'b0010, 1, 1, 4'b0010);
        v(0, 4'b1111, 1, 0, 1, 4'b0010, 1, 1, 4'b0010);
        v(0, 4'b1111, 1, 1, 1, 4'b0010, 1, 1, 4'b0010);
        v(0, 4'b1111, 0, 0, 1, 4'b0100, 2, 1, 4'b0000);
`endif

        // Driver: inputs change 1 time unit after the rising edge.
        for (int r = 0; r < stim.size(); r++) begin
            @(posedge clk);
            #1;
            rst       = stim[r].r;
            in_valid  = stim[r].iv;
            out_ready = stim[r].o;
            in_last   = stim[r].l;
            if (stim[r].c) begin
                exp_t e;
                e.row = r; e.g = stim[r].g; e.gi = stim[r].gi;
                e.ov = stim[r].ov; e.ir = stim[r].ir;
                sb.push_back(e);
            end
        end

        // Wait a bounded number of cycles for the scoreboard to drain.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, legal range 2..32.
REQ-002 Localparam IW = $clog2(N): width of gnt_idx.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  N  per-requester valid; bit k belongs to requester k.
REQ-006 in_ready  output  N  per-requester ready; bit k asserted only for the granted requester.
REQ-007 in_last  input  1  last-beat flag of the granted requester's stream (present only with ARB_PKT_LOCK_EN).
REQ-008 out_valid  output  1  granted requester has a beat for downstream.
REQ-009 out_ready  input  1  downstream accepts a beat.
REQ-010 gnt  output  N  registered one-hot grant; directly drives the sel input of a downstream onehot_mux.
REQ-011 gnt_idx  output  IW  binary index of the set gnt bit; 0 when gnt is 0.

Function
REQ-012 States: IDLE (gnt all-zero) and GRANT (exactly one gnt bit set); gnt never has more than one bit set.
REQ-013 Register ptr (IW bits) holds the highest-priority index; search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N wrap).
REQ-014 IDLE: if any in_valid bit is set, the first set bit in search order is granted at the next edge (one-cycle grant latency); else remain IDLE.
REQ-015 GRANT: out_valid = in_valid[granted]; in_ready[k] = out_ready & gnt[k]; all other in_ready bits 0.
REQ-016 Accept = out_valid & out_ready; grant is held, unchanged, on every cycle without an accept, including cycles where the granted in_valid is low.
REQ-017 Release event: accept (without ARB_PKT_LOCK_EN) or accept with in_last=1 (with ARB_PKT_LOCK_EN).
REQ-018 On release, ptr <= (granted index + 1) mod N at the same edge.
REQ-019 On release, re-arbitration is performed in the same cycle over current in_valid using the updated ptr; if a winner exists it is registered as gnt at that edge (zero-bubble hand-over), else go IDLE.
REQ-020 The just-released requester may win again at release only if no other in_valid bit is set.
REQ-021 out_valid is 0 in IDLE; gnt_idx always equals encode(gnt).
REQ-022 No combinational path from out_ready to out_valid or gnt.

Reset
REQ-023 While rst is high at a clock edge: state IDLE, gnt=0, gnt_idx=0, ptr=0, out_valid=0, in_ready=0.
REQ-024 rst asserted mid-grant discards the grant and lock immediately at that edge; in-flight beats are not completed.
REQ-025 First arbitration after reset deassertion uses ptr=0 (requester 0 highest priority).

Configuration
REQ-026 Macro ARB_PKT_LOCK_EN: when defined, in_last port exists and the grant is held across multiple accepted beats until the beat accepted with in_last=1.
REQ-027 When ARB_PKT_LOCK_EN is undefined, in_last port is absent and the grant is released after every accepted beat.

Verification
REQ-028 N=4, reset then in_valid=4'b1111, out_ready=1 constant -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, no bubble cycles.
REQ-029 N=4, only in_valid[2]=1, out_ready=0 for 5 cycles then 1 -> gnt=0100 held 6 cycles, one accept, in_ready=0100 only on accept cycle, then gnt=0100 again (sole requester).
REQ-030 N=4, ptr=3 after granting requester 2, in_valid=4'b0011 -> next gnt=0001 (wrap-around from index 3 to 0).
REQ-031 ARB_PKT_LOCK_EN, requester 1 sends 3 beats (in_last on 3rd) with in_valid=4'b1111 -> gnt=0010 held for all 3 accepts, then gnt=0100.
REQ-032 rst pulsed while gnt=1000 with out_ready=0 -> next cycle gnt=0, out_valid=0, then first grant goes to lowest-index valid requester.
